// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with valid/ready on both sides.
// Optional leading-zero mask output enabled by defining RESULT_BCD_BLANK_EN.
module result_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef RESULT_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W      = 4 * DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

  generate
    if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("result_bcd_converter: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
             DIGITS, WIDTH, MIN_DIGITS);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   bin;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   corrected;
  logic [BCD_W-1:0]   next_scratch;
  logic [CNT_W-1:0]   cnt;

  // Digits 5..9 become 8..12, so the 4-bit add never wraps.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [BCD_W-1:0] correct_all(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = add3(s[4*i +: 4]);
    return r;
  endfunction

`ifdef RESULT_BCD_BLANK_EN
  // Digit 0 is never blanked so a zero result still shows one "0".
  function automatic logic [DIGITS-1:0] lead_blank(input logic [BCD_W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'd0) seen = 1'b1;
      m[i] = !seen;
    end
    return m;
  endfunction
`endif

  always_comb begin
    corrected    = correct_all(scratch);
    next_scratch = BCD_W'({corrected, bin[WIDTH-1]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      bin       <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd       <= '0;
`ifdef RESULT_BCD_BLANK_EN
      blank     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin      <= in_data;
            scratch  <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          bin     <= {bin[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bcd       <= next_scratch;
`ifdef RESULT_BCD_BLANK_EN
            blank     <= lead_blank(next_scratch);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed + randomized bench for result_bcd_converter; reference built from decimal arithmetic.
// Checks blank as well when RESULT_BCD_BLANK_EN is defined.
module tb_result_bcd_converter;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
`ifdef RESULT_BCD_BLANK_EN
  logic [DIGITS-1:0]   blank;
`endif

  int passed = 0;
  int total  = 0;

  result_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bcd(bcd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
`ifdef RESULT_BCD_BLANK_EN
    ,
    .blank(blank)
`endif
  );

  always #5 clk = ~clk;

  // Decimal digits of v, least significant first, by repeated division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] r;
    longint unsigned     x;
    r = '0;
    x = longint'(v);
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input logic [WIDTH-1:0] v);
    logic [DIGITS-1:0] m;
    longint unsigned   x;
    int                nd;
    x  = longint'(v);
    nd = 1;
    while (x >= 10) begin x = x / 10; nd++; end
    for (int i = 0; i < DIGITS; i++) m[i] = (i >= nd);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Accept v, wait for the result, check it, then release it.
  task automatic convert(input logic [WIDTH-1:0] v, input string tag);
    int n;
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    chk({tag, " in_ready_after_accept"}, 64'(in_ready), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk({tag, " latency"}, 64'(n), 64'(WIDTH));
    chk({tag, " bcd"}, 64'(bcd), 64'(ref_bcd(v)));
`ifdef RESULT_BCD_BLANK_EN
    chk({tag, " blank"}, 64'(blank), 64'(ref_blank(v)));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid_released"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0]    v;
    logic [4*DIGITS-1:0] held;
    logic                bad;
    int                  n;
    int                  t_first;
    int                  t_second;
    logic [4*DIGITS-1:0] r_first;
    logic [4*DIGITS-1:0] r_second;

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset bcd", 64'(bcd), 64'd0);
`ifdef RESULT_BCD_BLANK_EN
    chk("reset blank", 64'(blank), 64'd0);
`endif

    // Directed values, including the boundaries.
    convert(32'd287, "v287");
    chk("v287 literal", 64'(bcd), 64'h0000000287);
    convert(32'd0, "zero");
    convert(32'hFFFF_FFFF, "max");
    chk("max literal", 64'(bcd), 64'h4294967295);

    // Randomized values across magnitudes.
    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 0) ? $urandom : $urandom_range(0, 99999);
      convert(v, $sformatf("rand%0d", i));
    end

    // Backpressure: result held, a second word offered and refused.
    in_data  = 32'd999;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("bp latency", 64'(n), 64'(WIDTH));
    held = bcd;
    bad  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_data  = 32'd257;
      in_valid = (c == 5);
      out_ready = (c == 10) ? 1'b0 : 1'b0;
      tick();
      if (!out_valid || bcd !== held || in_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp hold stable", 64'(bad), 64'd0);
    chk("bp bcd", 64'(bcd), 64'h0000000999);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp idle after release", 64'(in_ready), 64'd1);
    convert(32'd257, "bp257");
    chk("bp257 literal", 64'(bcd), 64'h0000000257);

    // Reset during conversion aborts without a result.
    in_data  = 32'd23;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort bcd", 64'(bcd), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("abort no pulse", 64'(bad), 64'd0);
    convert(32'd23, "after_abort");
    chk("after_abort literal", 64'(bcd), 64'h0000000023);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    in_data   = 32'd287;
    in_valid  = 1'b1;
    tick();
    in_data  = 32'd257;
    n        = 0;
    t_first  = -1;
    t_second = -1;
    r_first  = '0;
    r_second = '0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (out_valid) begin
        n++;
        if (t_first < 0) begin t_first = c; r_first = bcd; end
        else if (t_second < 0) begin t_second = c; r_second = bcd; end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b pulse count", 64'(n), 64'd2);
    chk("b2b first time", 64'(t_first), 64'(WIDTH));
    chk("b2b spacing", 64'(t_second - t_first), 64'(WIDTH + 2));
    chk("b2b first bcd", 64'(r_first), 64'h0000000287);
    chk("b2b second bcd", 64'(r_second), 64'h0000000257);
    do_reset();
    chk("final reset in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Sequential binary-to-BCD converter directly downstream of the floating_point datapath.
- Takes its 32-bit unsigned result word and produces packed BCD digits for the display/readout stage.
- Uses the iterative shift-and-add-3 (double dabble) method, one bit per clock, to keep area small.
- Valid/ready handshakes on both sides; one conversion in flight at a time.

Parameters:
- WIDTH, 32, bit width of the binary input word.
- DIGITS, 10, number of BCD output digits. Must satisfy DIGITS >= ceil(WIDTH*log10(2)); 10 covers 4294967295. A smaller value is a configuration error, flagged by a simulation-only check.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  binary value, normally floating_point's out.
- in_valid  in  1  in_data valid.
- in_ready  out  1  converter can accept a word.
- bcd  out  4*DIGITS  packed BCD; digit i at bits [4i+3:4i], digit 0 least significant.
- out_valid  out  1  bcd holds a completed conversion.
- out_ready  in  1  consumer accepts bcd.
- busy  out  1  conversion in progress (state SHIFT).
- blank  out  DIGITS  leading-zero mask; present only with RESULT_BCD_BLANK_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst high at a rising edge):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - bcd = 0; internal shift register and counter = 0; blank = 0 when the option is compiled in.
- Reset mid-conversion or mid-hold aborts without any output pulse. rst has priority over every other input.
- State machine:
  - IDLE:
    - in_ready = 1.
    - When in_valid = 1 at an edge: latch in_data into the binary shift register, clear the BCD scratch register, clear counter, go to SHIFT.
  - SHIFT:
    - in_ready = 0, busy = 1.
    - Each edge runs one iteration: every scratch digit >= 5 gets +3 (combinational, all digits in parallel), then {scratch, binary} shifts left by 1, counter increments.
    - After the iteration with counter = WIDTH-1, go to DONE. Copy the final scratch value into bcd on that same edge.
  - DONE:
    - out_valid = 1; bcd stable.
    - When out_ready = 1 at an edge: go to IDLE, out_valid drops to 0. bcd keeps its last value (not cleared).
    - in_valid is ignored here.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready are both 1 at an edge.
  - Output transfer occurs when out_valid & out_ready are both 1 at an edge.
  - out_valid, once set, holds until the transfer; no retraction.
  - in_data is sampled only on the accept edge; later changes have no effect.
- Timing:
  - Latency: out_valid is first visible exactly WIDTH cycles after the accept edge (32 by default).
  - Throughput: minimum WIDTH+2 cycles per word (accept, WIDTH iterations, release).
- Arithmetic:
  - Unsigned only.
  - Each +3 correction is 4-bit and never overflows, because it is applied only for digits 5..9.
  - Digits above what WIDTH can reach stay 0.
- Boundary values:
  - in_data = 0 gives all digits 0.
  - in_data = 2^WIDTH-1 gives the full decimal value with no truncation.
  - out_ready held high in IDLE or SHIFT has no effect.

Optional Feature:
- Macro: RESULT_BCD_BLANK_EN.
- With it defined:
  - The blank port exists and is registered alongside bcd on the same edge.
  - blank[i] = 1 when digit i and all higher digits are 0, for i >= 1.
  - blank[0] is always 0, so the value zero shows a single "0".
  - blank keeps its value with bcd.
- Without it:
  - No blank port and no blanking logic.
  - The display stage treats all digits as shown.

Test Plan:
1. Reset, then in_data = 287 with in_valid for 1 cycle. Required:
   - in_ready = 0 the next cycle.
   - out_valid rises 32 cycles after accept.
   - bcd = 40'h0000000287.
   - With the option: blank = 10'b1111111000.
2. in_data = 0. Required: bcd = 0, out_valid after 32 cycles; with the option, blank = 10'b1111111110.
3. in_data = 32'hFFFFFFFF. Required: bcd = 40'h4294967295; with the option, blank = 0.
4. Backpressure: hold out_ready = 0 for 20 cycles after out_valid, and pulse in_valid with 257 during that time. Required:
   - out_valid stays 1 and bcd is unchanged.
   - in_ready stays 0; 257 is not accepted.
   - Raise out_ready: IDLE next cycle. A new in_valid with 257 then yields bcd = 40'h0000000257.
5. Reset mid-op: assert rst on iteration 10 of converting 23. Required:
   - Next cycle: in_ready = 1, busy = 0, out_valid = 0, bcd = 0.
   - No out_valid ever pulses for 23.
   - A following conversion of 23 gives bcd = 40'h0000000023.
6. Back-to-back: in_valid held high with 287 then 257, out_ready tied high. Required:
   - Two results, 287 then 257, exactly WIDTH+2 = 34 cycles apart.
   - Each out_valid lasts exactly 1 cycle.
